// File: rtl/vec_result_sign_restore.sv
// Restores per-lane product sign by lane-isolated two's-complement negation,
// then selects low/high half per opcode behind a 2-stage valid/ready pipeline.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake
//   product_mag         lane-packed unsigned product magnitudes
//   neg_lane            per-lane negate flag (lane i = bit i)
//   precision           00=8b, 01=16b, 10=32b elements, 11=illegal
//   opcode              00=MUL (low half), others = high half
//   out_valid/out_ready output handshake
//   result              packed per-lane selected halves
//   illegal_prec        beat carried precision 11 (qualified by out_valid)
module vec_result_sign_restore #(
  parameter int PROD_W  = 64,
  parameter int CHUNK_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PROD_W-1:0]   product_mag,
  input  logic [3:0]          neg_lane,
  input  logic [1:0]          precision,
  input  logic [1:0]          opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W/2-1:0] result,
  output logic                illegal_prec
);

  localparam int NCH  = PROD_W / CHUNK_W;
  localparam int NSEG = CHUNK_W / 4;
  localparam int LOG0 = $clog2(16 / CHUNK_W);
  localparam int RW   = PROD_W / 2;

  // Chunks per lane is (16/CHUNK_W) << prec, always a power of two.
  function automatic logic [1:0] lane_of(input int k, input logic [1:0] prec);
    int sh;
    sh = LOG0 + int'(prec);
    return 2'(k >> sh);
  endfunction

  function automatic logic is_lsb(input int k, input logic [1:0] prec);
    int sh;
    sh = LOG0 + int'(prec);
    return ((k >> sh) << sh) == k;
  endfunction

  logic              s1_valid;
  logic [PROD_W-1:0] s1_d;
  logic [PROD_W-1:0] s1_inc;
  logic [NCH-1:0]    s1_p;
  logic [1:0]        s1_prec;
  logic [1:0]        s1_op;
  logic [3:0]        s1_neg;
  logic              s1_ill;

  logic adv2;
  logic adv1;

  assign adv2     = !out_valid | out_ready;
  assign adv1     = adv2 | !s1_valid;
  assign in_ready = adv1;

  logic [PROD_W-1:0] d_c;
  logic [PROD_W-1:0] inc_c;
  logic [NCH-1:0]    p_c;

  always_comb begin : s1_comb
    logic       c;
    logic [3:0] seg;
    d_c   = '0;
    inc_c = '0;
    p_c   = '0;
    c     = 1'b0;
    seg   = '0;
    for (int k = 0; k < NCH; k++) begin
      d_c[k*CHUNK_W +: CHUNK_W] = product_mag[k*CHUNK_W +: CHUNK_W]
        ^ {CHUNK_W{neg_lane[lane_of(k, precision)]}};
      p_c[k] = &d_c[k*CHUNK_W +: CHUNK_W];
      // Chunk +1: each 4-bit segment picks seg or seg+1 by its carry.
      c = 1'b1;
      for (int j = 0; j < NSEG; j++) begin
        seg = d_c[k*CHUNK_W + j*4 +: 4];
        inc_c[k*CHUNK_W + j*4 +: 4] = c ? seg + 4'd1 : seg;
        c = c & (&seg);
      end
    end
  end

  logic [PROD_W-1:0] mag_c;
  logic [RW-1:0]     res_c;

  always_comb begin : s2_comb
    logic cin;
    logic cnext;
    logic hi;
    mag_c = '0;
    res_c = '0;
    cin   = 1'b0;
    cnext = 1'b0;
    hi    = s1_op != 2'b00;
    // Lane LSB chunk takes the lane's +1; carry out of lane MSB is dropped.
    for (int k = 0; k < NCH; k++) begin
      cin = is_lsb(k, s1_prec) ? s1_neg[lane_of(k, s1_prec)] : cnext;
      mag_c[k*CHUNK_W +: CHUNK_W] = cin
        ? s1_inc[k*CHUNK_W +: CHUNK_W]
        : s1_d[k*CHUNK_W +: CHUNK_W];
      cnext = cin & s1_p[k];
    end
    case (s1_prec)
      2'b00: begin
        for (int i = 0; i < PROD_W/16; i++)
          res_c[i*8 +: 8] = hi ? mag_c[i*16+8 +: 8] : mag_c[i*16 +: 8];
      end
      2'b01: begin
        for (int i = 0; i < PROD_W/32; i++)
          res_c[i*16 +: 16] = hi ? mag_c[i*32+16 +: 16] : mag_c[i*32 +: 16];
      end
      2'b10: begin
        for (int i = 0; i < PROD_W/64; i++)
          res_c[i*32 +: 32] = hi ? mag_c[i*64+32 +: 32] : mag_c[i*64 +: 32];
      end
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_d         <= '0;
      s1_inc       <= '0;
      s1_p         <= '0;
      s1_prec      <= '0;
      s1_op        <= '0;
      s1_neg       <= '0;
      s1_ill       <= 1'b0;
      out_valid    <= 1'b0;
      result       <= '0;
      illegal_prec <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_d    <= d_c;
          s1_inc  <= inc_c;
          s1_p    <= p_c;
          s1_prec <= precision;
          s1_op   <= opcode;
          s1_neg  <= neg_lane;
          s1_ill  <= precision == 2'b11;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result       <= res_c;
          illegal_prec <= s1_ill;
        end
      end
    end
  end

endmodule

// File: doc/vec_result_sign_restore.md
Name: vec_result_sign_restore

Overview:
- Result-side counterpart of the operand two's-complement stage in the vector Vedic multiplier.
- Receives unsigned product magnitudes from the Urdhva-Tiryakbhyam array, lane-packed by precision.
- Re-applies the product sign per lane by two's-complement negation, with no carry leaking across lane boundaries.
- Selects the low or high half of each lane product per opcode, behind a 2-stage valid/ready pipeline.

Parameters:
- PROD_W, 64, total product magnitude width (all lanes).
- CHUNK_W, 16, carry-resolution chunk width; must divide the smallest lane width (16).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- product_mag  in  64  lane-packed magnitudes:
  - prec 00: four 16-bit lanes
  - prec 01: two 32-bit lanes
  - prec 10: one 64-bit lane
- neg_lane  in  4  per-lane negate flag (lane i = bit i); only bits [lanes-1:0] are used
- precision  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
- opcode  in  2  00 = MUL (low half), 01 = MULH, 10 = MULHU, 11 = MULSU (high half)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  32  packed per-lane halves; lane i occupies bits [i*N +: N], N = element width
- illegal_prec  out  1  beat carried precision 11; qualified by out_valid

Behaviour:
- Reset (async, rst_n low): s1_valid = 0, s2_valid = 0, out_valid = 0, result = 0, illegal_prec = 0. in_ready = 1 after reset.
- Data registers are also cleared on reset. Reset mid-pipeline discards both stages with no partial output.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - Stage 2 advances when !s2_valid | out_ready.
  - Stage 1 advances when stage 2 advances or !s1_valid.
  - in_ready = !s1_valid | (stage 2 advance). This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - result and illegal_prec are held stable while out_valid & !out_ready. No beat is dropped or duplicated, and order is preserved.
- Latency: a beat accepted at edge t gives out_valid = 1 after edge t+2 when there is no backpressure. Full throughput is 1 beat per cycle.
- Stage 1 (edge t+1) registers:
  - conditioned data d = product_mag XOR (lane mask of negated lanes);
  - per-chunk all-ones propagate flags p[k] = &d[chunk k];
  - per-chunk incremented value d[chunk]+1, computed as a carry-select pair of 4-bit segments;
  - precision, opcode, neg_lane, illegal flag.
- Stage 2 (edge t+2):
  - Carry into chunk k:
    - k is a lane's LSB chunk: carry = neg of that lane.
    - otherwise: carry = carry_in[k-1] & p[k-1].
  - The chunk output selects the incremented or plain value by its carry.
  - Carry out of a lane's MSB chunk is discarded (this is the wrap-around, e.g. -0 = 0).
- Half select per lane of width 2N:
  - MUL: bits [N-1:0].
  - MULH / MULHU / MULSU: bits [2N-1:N].
  - Sign handling for MULHU and MULSU is already encoded upstream in neg_lane; this block does not reinterpret opcode for sign.
- Precision 11: result = 0, illegal_prec = 1, and the beat still flows through the pipeline normally.
- A lane with neg = 0 passes through unchanged regardless of neighbouring lanes.

Test Plan:
- prec 10, MUL, product_mag = 0x0000_0000_0000_0006, neg_lane = 0001 -> result 0xFFFF_FFFA, out_valid exactly 2 cycles after acceptance.
- Same beat with opcode MULH -> result 0xFFFF_FFFF. With neg_lane = 0000 -> 0x0000_0000.
- prec 00, MUL, lanes (3..0) = 0x0003, 0x0000, 0x0001, 0x0000, neg_lane = 0101 -> lane0 0x00, lane1 0x01, lane2 0x00, lane3 0x03, so result 0x0300_0100. This checks that the full carry through a zero lane does not leak into the next lane.
- prec 01, MULH, lanes = 0x0000_0001 (lane0, neg) and 0x0001_0000 (lane1, no neg) -> lane0 high = 0xFFFF, lane1 high = 0x0001, so result 0x0001_FFFF.
- Backpressure: hold out_ready = 0 and offer 3 back-to-back beats. in_ready drops after 2 are accepted. Release out_ready: the 3 results emerge in order, and result stays stable during the stall.
- Assert rst_n low for one cycle with both stages full -> out_valid = 0 and result = 0 immediately (async). No stale beat appears after release. A beat with precision 11 yields illegal_prec = 1 and result 0.
